// File: rtl/mips_test_sequencer.sv
// Run-control sequencer for the MIPS32 pipeline: streams a program into imem,
// initialises the register file, runs the core with a cycle limit and dumps registers.
module mips_test_sequencer #(
   parameter int DATA_W     = 32,
   parameter int IMEM_AW    = 10,
   parameter int PROG_DEPTH = 1024,
   parameter int NREGS      = 32,
   parameter int REG_AW     = 5,
   parameter int DUMP_REGS  = 6,
   parameter int INIT_MODE  = 1,
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 1000
) (
   input  logic               clk1,
   input  logic               rst,
   input  logic               start,
   input  logic               prog_valid,
   output logic               prog_ready,
   input  logic [DATA_W-1:0]  prog_data,
   input  logic               prog_last,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [DATA_W-1:0]  imem_wdata,
   output logic               rf_we,
   output logic [REG_AW-1:0]  rf_addr,
   output logic [DATA_W-1:0]  rf_wdata,
   input  logic [DATA_W-1:0]  rf_rdata,
   output logic               cpu_rst,
   output logic               cpu_run,
   input  logic               cpu_halted,
   output logic               dump_valid,
   input  logic               dump_ready,
   output logic [REG_AW-1:0]  dump_reg,
   output logic [DATA_W-1:0]  dump_data,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic               prog_ovf,
   output logic [CNT_W-1:0]   cycles
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_INIT, S_LAUNCH, S_RUN, S_DUMP, S_DONE
   } state_t;

   localparam logic [IMEM_AW:0]  DEPTH     = (IMEM_AW+1)'(PROG_DEPTH);
   localparam logic [REG_AW-1:0] INIT_LAST = REG_AW'(NREGS - 1);
   localparam logic [REG_AW-1:0] DUMP_LAST = REG_AW'(DUMP_REGS - 1);
   localparam logic [CNT_W-1:0]  CYC_MAX   = CNT_W'(MAX_CYCLES);

   state_t             state_r;
   logic [IMEM_AW:0]   widx_r;
   logic [REG_AW-1:0]  idx_r;
   logic [CNT_W-1:0]   cycles_r;
   logic               done_r;
   logic               timeout_r;
   logic               ovf_r;
   logic               in_range_s;
   logic [CNT_W-1:0]   cyc_inc_s;

   // Word index is one bit wider than the address so a full-depth program cannot wrap it
   assign in_range_s = (widx_r < DEPTH);
   assign cyc_inc_s  = (cycles_r == CYC_MAX) ? cycles_r : cycles_r + CNT_W'(1);

   assign done     = done_r;
   assign timeout  = timeout_r;
   assign prog_ovf = ovf_r;
   assign cycles   = cycles_r;

   // State decode of strobes; imem write data and dump data pass straight through
   always_comb begin
      prog_ready = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = {IMEM_AW{1'b0}};
      imem_wdata = {DATA_W{1'b0}};
      rf_we      = 1'b0;
      rf_addr    = {REG_AW{1'b0}};
      rf_wdata   = {DATA_W{1'b0}};
      cpu_rst    = 1'b0;
      cpu_run    = 1'b0;
      dump_valid = 1'b0;
      dump_reg   = {REG_AW{1'b0}};
      dump_data  = {DATA_W{1'b0}};
      busy       = 1'b0;
      case (state_r)
         S_LOAD: begin
            busy       = 1'b1;
            prog_ready = 1'b1;
            imem_we    = prog_valid & in_range_s;
            imem_addr  = widx_r[IMEM_AW-1:0];
            imem_wdata = prog_data;
         end
         S_INIT: begin
            busy    = 1'b1;
            rf_we   = 1'b1;
            rf_addr = idx_r;
            if (INIT_MODE != 0) begin
               rf_wdata = DATA_W'(idx_r);
            end else begin
               rf_wdata = {DATA_W{1'b0}};
            end
         end
         S_LAUNCH: begin
            busy    = 1'b1;
            cpu_rst = 1'b1;
         end
         S_RUN: begin
            busy    = 1'b1;
            cpu_run = 1'b1;
         end
         S_DUMP: begin
            busy       = 1'b1;
            rf_addr    = idx_r;
            dump_valid = 1'b1;
            dump_reg   = idx_r;
            dump_data  = rf_rdata;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Session FSM with its counters and sticky status flags
   always_ff @(posedge clk1) begin
      if (rst) begin
         state_r   <= S_IDLE;
         widx_r    <= {(IMEM_AW+1){1'b0}};
         idx_r     <= {REG_AW{1'b0}};
         cycles_r  <= {CNT_W{1'b0}};
         done_r    <= 1'b0;
         timeout_r <= 1'b0;
         ovf_r     <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_r   <= S_LOAD;
                  widx_r    <= {(IMEM_AW+1){1'b0}};
                  idx_r     <= {REG_AW{1'b0}};
                  cycles_r  <= {CNT_W{1'b0}};
                  done_r    <= 1'b0;
                  timeout_r <= 1'b0;
                  ovf_r     <= 1'b0;
               end
            end
            S_LOAD: begin
               if (prog_valid) begin
                  if (in_range_s) begin
                     widx_r <= widx_r + (IMEM_AW+1)'(1);
                  end else begin
                     ovf_r <= 1'b1;
                  end
                  if (prog_last) begin
                     state_r <= S_INIT;
                     idx_r   <= {REG_AW{1'b0}};
                  end
               end
            end
            S_INIT: begin
               if (idx_r == INIT_LAST) begin
                  state_r <= S_LAUNCH;
                  idx_r   <= {REG_AW{1'b0}};
               end else begin
                  idx_r <= idx_r + REG_AW'(1);
               end
            end
            S_LAUNCH: begin
               state_r <= S_RUN;
            end
            S_RUN: begin
               cycles_r <= cyc_inc_s;
               // Halt takes priority over the cycle limit when both land together
               if (cpu_halted) begin
                  state_r <= S_DUMP;
               end else if (cyc_inc_s == CYC_MAX) begin
                  state_r   <= S_DUMP;
                  timeout_r <= 1'b1;
               end
            end
            S_DUMP: begin
               if (dump_ready) begin
                  if (idx_r == DUMP_LAST) begin
                     state_r <= S_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     idx_r <= idx_r + REG_AW'(1);
                  end
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end
endmodule
